// File: rtl/stack_sequencer_if.sv
// Decoder / register file / program counter / memory bus signals driven by the stack sequencer.
// master: sequencer side (drives strobes, bus request, status); slave: environment side.
// Ports: op_* request, busy/done/error status, rf_* register file, pc_* program counter, mem_* bus.
interface stack_sequencer_if;
    logic        op_valid;
    logic [1:0]  op;
    logic [3:0]  op_reg;
    logic [31:0] op_target;
    logic        busy;
    logic        done;
    logic        error;
    logic [3:0]  rf_src_index;
    logic [31:0] rf_src_data;
    logic [31:0] rf_sp_data;
    logic        rf_write;
    logic [3:0]  rf_write_index;
    logic [31:0] rf_write_data;
    logic        rf_inc;
    logic        rf_dec;
    logic [3:0]  rf_incdec_index;
    logic [31:0] pc_read_data;
    logic        pc_write;
    logic [31:0] pc_write_data;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        input  op_valid, op, op_reg, op_target,
        input  rf_src_data, rf_sp_data, pc_read_data, mem_rdata, mem_ack,
        output busy, done, error, rf_src_index,
        output rf_write, rf_write_index, rf_write_data, rf_inc, rf_dec, rf_incdec_index,
        output pc_write, pc_write_data,
        output mem_req, mem_write, mem_address, mem_wdata
    );

    modport slave (
        output op_valid, op, op_reg, op_target,
        output rf_src_data, rf_sp_data, pc_read_data, mem_rdata, mem_ack,
        input  busy, done, error, rf_src_index,
        input  rf_write, rf_write_index, rf_write_data, rf_inc, rf_dec, rf_incdec_index,
        input  pc_write, pc_write_data,
        input  mem_req, mem_write, mem_address, mem_wdata
    );
endinterface

// File: rtl/stack_sequencer.sv
// Executes PUSH/POP/CALL/RET on a full-descending stack whose pointer is register SP_INDEX.
// Latency (zero-wait ack): PUSH/CALL done 3 cycles after accept, POP/RET 2, misaligned SP 1; +1 per bus wait.
// Backpressure: mem_req held until mem_ack; op_valid only sampled while idle (busy low).
// Ports: clock, reset (async active-high), bus = stack_sequencer_if.master.
module stack_sequencer #(
    parameter logic [3:0] SP_INDEX = 4'hf
) (
    input  logic                   clock,
    input  logic                   reset,
    stack_sequencer_if.master      bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADJUST,
        ST_MEM_WR,
        ST_MEM_RD,
        ST_COMPLETE
    } state_t;

    localparam logic [1:0] OP_PUSH = 2'd0;
    localparam logic [1:0] OP_POP  = 2'd1;
    localparam logic [1:0] OP_CALL = 2'd2;
    localparam logic [1:0] OP_RET  = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  op_reg_q, op_reg_d;
    logic [31:0] target_q, target_d;
    logic [31:0] operand_q, operand_d;
    logic        err_q, err_d;

    // State and operand registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= 2'd0;
            op_reg_q  <= 4'd0;
            target_q  <= 32'd0;
            operand_q <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            op_reg_q  <= op_reg_d;
            target_q  <= target_d;
            operand_q <= operand_d;
            err_q     <= err_d;
        end
    end

    // Next-state and operand capture
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        op_reg_d  = op_reg_q;
        target_d  = target_q;
        operand_d = operand_q;
        err_d     = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    op_d      = bus.op;
                    op_reg_d  = bus.op_reg;
                    target_d  = bus.op_target;
                    operand_d = (bus.op == OP_CALL) ? bus.pc_read_data : bus.rf_src_data;
                    // A misaligned SP aborts before any SP change or bus cycle.
                    err_d     = (bus.rf_sp_data[1:0] != 2'b00);
                    if (bus.rf_sp_data[1:0] != 2'b00)
                        state_d = ST_COMPLETE;
                    else if (bus.op == OP_PUSH || bus.op == OP_CALL)
                        state_d = ST_ADJUST;
                    else
                        state_d = ST_MEM_RD;
                end
            end
            ST_ADJUST:   state_d = ST_MEM_WR;
            ST_MEM_WR:   if (bus.mem_ack) state_d = ST_COMPLETE;
            ST_MEM_RD: begin
                if (bus.mem_ack) begin
                    operand_d = bus.mem_rdata;
                    state_d   = ST_COMPLETE;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy           = (state_q != ST_IDLE);
        bus.done           = (state_q == ST_COMPLETE);
        bus.error          = (state_q == ST_COMPLETE) && err_q;
        bus.rf_write       = 1'b0;
        bus.rf_write_index = 4'd0;
        bus.rf_write_data  = 32'd0;
        bus.rf_inc         = 1'b0;
        bus.rf_dec         = (state_q == ST_ADJUST);
        bus.pc_write       = 1'b0;
        bus.pc_write_data  = 32'd0;
        bus.mem_req        = (state_q == ST_MEM_WR) || (state_q == ST_MEM_RD);
        bus.mem_write      = (state_q == ST_MEM_WR);
        bus.mem_address    = bus.mem_req ? bus.rf_sp_data : 32'd0;
        bus.mem_wdata      = (state_q == ST_MEM_WR) ? operand_q : 32'd0;
        if (state_q == ST_COMPLETE && !err_q) begin
            unique case (op_q)
                OP_POP: begin
                    bus.rf_write       = 1'b1;
                    bus.rf_write_index = op_reg_q;
                    bus.rf_write_data  = operand_q;
                    // Popping into SP itself: the loaded value replaces the pointer.
                    bus.rf_inc         = (op_reg_q != SP_INDEX);
                end
                OP_RET: begin
                    bus.pc_write      = 1'b1;
                    bus.pc_write_data = operand_q;
                    bus.rf_inc        = 1'b1;
                end
                OP_CALL: begin
                    bus.pc_write      = 1'b1;
                    bus.pc_write_data = target_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.rf_src_index    = bus.op_reg;
    assign bus.rf_incdec_index = SP_INDEX;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    stack_sequencer_if sif ();

    stack_sequencer #(.SP_INDEX(4'hf)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    // Environment model: register file, PC, word memory, bus responder
    logic [31:0] regs [0:15];
    logic [31:0] pc;
    logic [31:0] mem [0:255];
    int          ack_delay = 0;
    int          req_cnt   = 0;
    logic        pre_en    = 1'b0;
    int          pre_kind  = 0;
    logic [31:0] pre_addr  = 32'd0;
    logic [31:0] pre_val   = 32'd0;

    assign sif.rf_src_data  = regs[sif.rf_src_index];
    assign sif.rf_sp_data   = regs[15];
    assign sif.pc_read_data = pc;
    assign sif.mem_ack      = sif.mem_req && (req_cnt == ack_delay);
    assign sif.mem_rdata    = sif.mem_ack ? mem[sif.mem_address[9:2]] : 32'd0;

    always @(posedge clock) begin
        if (sif.mem_req && !sif.mem_ack) req_cnt <= req_cnt + 1;
        else                             req_cnt <= 0;
        if (pre_en) begin
            if (pre_kind == 0)      regs[pre_addr[3:0]] <= pre_val;
            else if (pre_kind == 1) pc <= pre_val;
            else                    mem[pre_addr[9:2]] <= pre_val;
        end else begin
            if (sif.rf_write) regs[sif.rf_write_index] <= sif.rf_write_data;
            if (sif.rf_inc)   regs[15] <= regs[15] + 32'd4;
            if (sif.rf_dec)   regs[15] <= regs[15] - 32'd4;
            if (sif.pc_write) pc <= sif.pc_write_data;
            if (sif.mem_req && sif.mem_ack && sif.mem_write)
                mem[sif.mem_address[9:2]] <= sif.mem_wdata;
        end
    end

    // Per-cycle event counters
    int n_done = 0, n_err = 0, n_dec = 0, n_inc = 0, n_req = 0;
    always @(negedge clock) begin
        if (sif.done)    n_done++;
        if (sif.error)   n_err++;
        if (sif.rf_dec)  n_dec++;
        if (sif.rf_inc)  n_inc++;
        if (sif.mem_req) n_req++;
    end

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic preload(input int kind, input logic [31:0] addr, input logic [31:0] val);
        @(negedge clock);
        pre_en = 1'b1; pre_kind = kind; pre_addr = addr; pre_val = val;
        @(negedge clock);
        pre_en = 1'b0;
    endtask

    // Issues one op; dc = cycle (after the accept edge) in which done was seen, 0 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [3:0] r, input logic [31:0] t,
                          input bit hold, output int dc, output logic b1);
        @(negedge clock);
        sif.op = o; sif.op_reg = r; sif.op_target = t; sif.op_valid = 1'b1;
        @(posedge clock);
        #1;
        if (!hold) sif.op_valid = 1'b0;
        dc = 0;
        b1 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (k == 1) b1 = sif.busy;
            if (sif.done) begin
                dc = k;
                break;
            end
        end
        sif.op_valid = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    int   dc;
    logic b1;
    int   s_done, s_err, s_dec, s_inc, s_req;
    bit   seen_req;

    task automatic snap();
        s_done = n_done; s_err = n_err; s_dec = n_dec; s_inc = n_inc; s_req = n_req;
    endtask

    initial begin
        sif.op_valid = 1'b0; sif.op = 2'd0; sif.op_reg = 4'd7; sif.op_target = 32'd0;
        repeat (2) @(negedge clock);
        check("rst_busy",   {31'd0, sif.busy},    32'd0);
        check("rst_done",   {31'd0, sif.done},    32'd0);
        check("rst_error",  {31'd0, sif.error},   32'd0);
        check("rst_req",    {31'd0, sif.mem_req}, 32'd0);
        check("rst_strobe", {28'd0, sif.rf_write, sif.rf_inc, sif.rf_dec, sif.pc_write}, 32'd0);
        check("rst_src_idx",   {28'd0, sif.rf_src_index},    32'd7);
        check("rst_incdec_idx", {28'd0, sif.rf_incdec_index}, 32'hf);
        reset = 1'b0;

        // PUSH r3, zero-wait ack
        preload(0, 32'd15, 32'h100);
        preload(0, 32'd3, 32'hdeadbeef);
        ack_delay = 0; snap();
        run_op(2'd0, 4'd3, 32'd0, 1'b0, dc, b1);
        check("push_busy",  {31'd0, b1}, 32'd1);
        check("push_cycle", dc, 32'd3);
        check("push_mem",   mem[8'h3f], 32'hdeadbeef);
        check("push_sp",    regs[15], 32'hfc);
        check("push_dec",   n_dec - s_dec, 32'd1);
        check("push_req",   n_req - s_req, 32'd1);
        check("push_done",  n_done - s_done, 32'd1);

        // POP r5, ack after two wait cycles
        ack_delay = 2; snap();
        run_op(2'd1, 4'd5, 32'd0, 1'b0, dc, b1);
        check("pop_cycle", dc, 32'd4);
        check("pop_req",   n_req - s_req, 32'd3);
        check("pop_r5",    regs[5], 32'hdeadbeef);
        check("pop_sp",    regs[15], 32'h100);
        check("pop_done",  n_done - s_done, 32'd1);

        // POP into SP: loaded value wins, no increment
        preload(0, 32'd15, 32'hfc);
        ack_delay = 0; snap();
        run_op(2'd1, 4'hf, 32'd0, 1'b0, dc, b1);
        check("popsp_cycle", dc, 32'd2);
        check("popsp_sp",    regs[15], 32'hdeadbeef);
        check("popsp_inc",   n_inc - s_inc, 32'd0);

        // CALL 0x1000 from PC 0x40, one wait cycle
        preload(1, 32'd0, 32'h40);
        preload(0, 32'd15, 32'h200);
        ack_delay = 1; snap();
        run_op(2'd2, 4'd0, 32'h1000, 1'b0, dc, b1);
        check("call_cycle", dc, 32'd4);
        check("call_mem",   mem[8'h7f], 32'h40);
        check("call_pc",    pc, 32'h1000);
        check("call_sp",    regs[15], 32'h1fc);

        // RET
        ack_delay = 0; snap();
        run_op(2'd3, 4'd0, 32'd0, 1'b0, dc, b1);
        check("ret_cycle", dc, 32'd2);
        check("ret_pc",    pc, 32'h40);
        check("ret_sp",    regs[15], 32'h200);
        check("ret_inc",   n_inc - s_inc, 32'd1);

        // Misaligned SP
        preload(0, 32'd15, 32'h102);
        snap();
        run_op(2'd0, 4'd3, 32'd0, 1'b0, dc, b1);
        check("mis_cycle", dc, 32'd1);
        check("mis_error", n_err - s_err, 32'd1);
        check("mis_req",   n_req - s_req, 32'd0);
        check("mis_dec",   n_dec - s_dec, 32'd0);
        check("mis_sp",    regs[15], 32'h102);

        // SP wrap with op_valid held high throughout
        preload(0, 32'd15, 32'h0);
        preload(0, 32'd3, 32'h12345678);
        snap();
        run_op(2'd0, 4'd3, 32'd0, 1'b1, dc, b1);
        repeat (4) @(negedge clock);
        check("wrap_cycle", dc, 32'd3);
        check("wrap_mem",   mem[8'hff], 32'h12345678);
        check("wrap_sp",    regs[15], 32'hfffffffc);
        check("hold_done",  n_done - s_done, 32'd1);
        check("hold_dec",   n_dec - s_dec, 32'd1);

        // Reset while a write is waiting for ack
        preload(0, 32'd15, 32'h300);
        preload(2, 32'h2fc, 32'ha5a5a5a5);
        ack_delay = 10;
        @(negedge clock);
        sif.op = 2'd0; sif.op_reg = 4'd3; sif.op_valid = 1'b1;
        @(posedge clock);
        #1 sif.op_valid = 1'b0;
        seen_req = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (sif.mem_req) begin
                seen_req = 1'b1;
                break;
            end
        end
        check("mid_req_seen", {31'd0, seen_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_req",  {31'd0, sif.mem_req}, 32'd0);
        check("mid_rst_busy", {31'd0, sif.busy},    32'd0);
        check("mid_rst_done", {31'd0, sif.done},    32'd0);
        @(negedge clock);
        reset = 1'b0;
        ack_delay = 0;
        run_op(2'd1, 4'd6, 32'd0, 1'b0, dc, b1);
        check("after_rst_cycle", dc, 32'd2);
        check("after_rst_r6",    regs[6], 32'ha5a5a5a5);
        check("after_rst_sp",    regs[15], 32'h300);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
